// File: rtl/fir_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fir_run_sequencer
// Brief    : Sequences FIR coefficient generation, coefficient handoff and
//            sample processing; optional FIR_SEQ_AUTO_RELOAD_EN reconfigures
//            automatically when the requested fs/fln settle on new values.
// Revision : 1.0 - initial release
// ============================================================================
module fir_run_sequencer #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int DRAIN_CYC   = 32,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      cfg_fs,
    input  logic [15:0]      cfg_fln,
    input  logic             cfg_load,
    input  logic             run,
    input  logic             coef_busy,
    input  logic             fir_ready,
    input  logic             fir_valid,
    output logic [15:0]      fs_out,
    output logic [15:0]      fln_out,
    output logic             en_fir_top,
    output logic             en_fir_deal,
    output logic [2:0]       state,
    output logic             cfg_done,
    output logic             err_timeout,
    output logic [CNT_W-1:0] sample_cnt
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_LATCH    = 3'd1;
    localparam logic [2:0] c_GEN      = 3'd2;
    localparam logic [2:0] c_WAIT_RDY = 3'd3;
    localparam logic [2:0] c_RUN      = 3'd4;
    localparam logic [2:0] c_DRAIN    = 3'd5;
    localparam logic [2:0] c_ERR      = 3'd6;

    // One phase counter serves LATCH, GEN and DRAIN; it restarts on every state entry.
    localparam int c_TO_CYC  = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC : 1;
    localparam int c_DR_CYC  = (DRAIN_CYC > 0) ? DRAIN_CYC : 1;
    localparam int c_PH_MAX  = (c_TO_CYC > c_DR_CYC) ? c_TO_CYC : c_DR_CYC;
    localparam int c_PH_W    = $clog2(c_PH_MAX + 2);

    localparam logic [c_PH_W-1:0] c_PH_ONES   = {c_PH_W{1'b1}};
    localparam logic [c_PH_W-1:0] c_LATCH_END = c_PH_W'(1);
    localparam logic [c_PH_W-1:0] c_TO_END    = c_PH_W'(c_TO_CYC - 1);
    localparam logic [c_PH_W-1:0] c_DR_END    = c_PH_W'(c_DR_CYC - 1);
    localparam logic [CNT_W-1:0]  c_CNT_ONES  = {CNT_W{1'b1}};

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [c_PH_W-1:0] r_ph;
    logic [15:0]       r_fs;
    logic [15:0]       r_fln;
    logic              r_busy_d;
    logic              r_seen_rise;
    logic              r_deal;
    logic              r_done;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_auto;
    logic              w_fall;
    logic              w_enter_latch;
    logic              w_state_chg;

`ifdef FIR_SEQ_AUTO_RELOAD_EN
    logic r_diff_d;
    logic w_diff;

    assign w_diff = (cfg_fs != r_fs) || (cfg_fln != r_fln);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_diff_d <= 1'b0;
        end else begin
            r_diff_d <= (r_state == c_RUN) && w_diff;
        end
    end

    assign w_auto = (r_state == c_RUN) && w_diff && r_diff_d;
`else
    assign w_auto = 1'b0;
`endif

    assign w_fall = (r_state == c_GEN) && r_seen_rise && r_busy_d && !coef_busy;

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (cfg_load) w_next = c_LATCH;
            end
            c_LATCH: begin
                if (!cfg_load && (r_ph == c_LATCH_END)) w_next = c_GEN;
            end
            c_GEN: begin
                if (cfg_load)              w_next = c_LATCH;
                else if (w_fall)           w_next = c_WAIT_RDY;
                else if (r_ph == c_TO_END) w_next = c_ERR;
            end
            c_WAIT_RDY: begin
                if (cfg_load)       w_next = c_LATCH;
                else if (fir_ready) w_next = c_RUN;
            end
            c_RUN: begin
                if (cfg_load || w_auto) w_next = c_DRAIN;
            end
            c_DRAIN: begin
                if (cfg_load || (r_ph == c_DR_END)) w_next = c_LATCH;
            end
            c_ERR: begin
                if (cfg_load) w_next = c_LATCH;
            end
            default: w_next = c_IDLE;
        endcase
    end

    // A load while already in LATCH counts as a fresh entry.
    assign w_enter_latch = (w_next == c_LATCH) && ((r_state != c_LATCH) || cfg_load);
    assign w_state_chg   = (w_next != r_state) || w_enter_latch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_ph    <= '0;
        end else begin
            r_state <= w_next;
            if (w_state_chg)
                r_ph <= '0;
            else if (r_ph != c_PH_ONES)
                r_ph <= r_ph + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fs  <= '0;
            r_fln <= '0;
        end else if (w_enter_latch) begin
            r_fs  <= cfg_fs;
            r_fln <= cfg_fln;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy_d    <= 1'b0;
            r_seen_rise <= 1'b0;
        end else begin
            r_busy_d <= coef_busy;
            if (w_state_chg)
                r_seen_rise <= 1'b0;
            else if ((r_state == c_GEN) && coef_busy && !r_busy_d)
                r_seen_rise <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deal <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_deal <= (r_state == c_RUN) && (w_next == c_RUN) && run && fir_ready;
            r_done <= (r_state == c_WAIT_RDY) && (w_next == c_RUN);
            if ((r_state == c_ERR) && cfg_load)
                r_err <= 1'b0;
            else if ((r_state == c_GEN) && (w_next == c_ERR))
                r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if ((r_state != c_RUN) && (w_next == c_RUN)) begin
            r_cnt <= '0;
        end else if ((r_state == c_RUN) && fir_valid && (r_cnt != c_CNT_ONES)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign fs_out      = r_fs;
    assign fln_out     = r_fln;
    assign en_fir_top  = (r_state == c_GEN) || (r_state == c_WAIT_RDY) ||
                         (r_state == c_RUN) || (r_state == c_DRAIN);
    assign en_fir_deal = r_deal;
    assign state       = r_state;
    assign cfg_done    = r_done;
    assign err_timeout = r_err;
    assign sample_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fir_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_run_sequencer
// Brief    : Directed bench; expected state transitions go through a queue
//            that a negedge monitor drains as the DUT changes state.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_run_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cfg_fs;
    logic [15:0] cfg_fln;
    logic        cfg_load;
    logic        run;
    logic        coef_busy;
    logic        fir_ready;
    logic        fir_valid;
    logic [15:0] fs_out;
    logic [15:0] fln_out;
    logic        en_fir_top;
    logic        en_fir_deal;
    logic [2:0]  state;
    logic        cfg_done;
    logic        err_timeout;
    logic [31:0] sample_cnt;

    int n_chk = 0;
    int n_err = 0;

    typedef struct packed {
        logic [2:0]  st;
        logic [15:0] fs;
        logic [15:0] fln;
        logic        err;
        logic [31:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] prev_st = 3'd0;

    fir_run_sequencer #(
        .TIMEOUT_CYC (64),
        .DRAIN_CYC   (32),
        .CNT_W       (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_fs      (cfg_fs),
        .cfg_fln     (cfg_fln),
        .cfg_load    (cfg_load),
        .run         (run),
        .coef_busy   (coef_busy),
        .fir_ready   (fir_ready),
        .fir_valid   (fir_valid),
        .fs_out      (fs_out),
        .fln_out     (fln_out),
        .en_fir_top  (en_fir_top),
        .en_fir_deal (en_fir_deal),
        .state       (state),
        .cfg_done    (cfg_done),
        .err_timeout (err_timeout),
        .sample_cnt  (sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push(input logic [2:0] s, input logic [15:0] f, input logic [15:0] l,
                        input logic e, input logic [31:0] c);
        exp_t x;
        x.st  = s;
        x.fs  = f;
        x.fln = l;
        x.err = e;
        x.cnt = c;
        exp_q.push_back(x);
    endtask

    // Scoreboard monitor: every state change must match the next queued expectation.
    always @(negedge clk) begin
        exp_t x;
        exp_t a;
        if (!rst_n) begin
            prev_st = state;
        end else if (state !== prev_st) begin
            a.st  = state;
            a.fs  = fs_out;
            a.fln = fln_out;
            a.err = err_timeout;
            a.cnt = sample_cnt;
            n_chk++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_transition actual state=%0d required none", state);
            end else begin
                x = exp_q.pop_front();
                if (a !== x) begin
                    n_err++;
                    $display("FAIL transition actual st=%0d fs=%0d fln=%0d err=%0d cnt=%0d required st=%0d fs=%0d fln=%0d err=%0d cnt=%0d",
                             a.st, a.fs, a.fln, a.err, a.cnt, x.st, x.fs, x.fln, x.err, x.cnt);
                end
            end
            prev_st = state;
        end
    end

    task automatic chk_reset_values(input string tag);
        chk({tag, "_state"},  state, 0);
        chk({tag, "_fs"},     fs_out, 0);
        chk({tag, "_fln"},    fln_out, 0);
        chk({tag, "_top"},    en_fir_top, 0);
        chk({tag, "_deal"},   en_fir_deal, 0);
        chk({tag, "_done"},   cfg_done, 0);
        chk({tag, "_err"},    err_timeout, 0);
        chk({tag, "_cnt"},    sample_cnt, 0);
    endtask

    initial begin
        rst_n = 1'b0; cfg_fs = '0; cfg_fln = '0; cfg_load = 1'b0;
        run = 1'b0; coef_busy = 1'b0; fir_ready = 1'b0; fir_valid = 1'b0;
        tick(3);
        chk_reset_values("reset");
        rst_n = 1'b1;
        tick(2);

        // Nominal bring-up: 48 kHz / 4 kHz
        cfg_fs = 16'd48000; cfg_fln = 16'd4000; cfg_load = 1'b1;
        push(3'd1, 16'd48000, 16'd4000, 1'b0, 32'd0);
        tick(); cfg_load = 1'b0;
        chk("latch_fs", fs_out, 48000);
        chk("latch_fln", fln_out, 4000);
        chk("latch_top_c1", en_fir_top, 0);
        tick();
        chk("latch_state_c2", state, 1);
        chk("latch_top_c2", en_fir_top, 0);
        push(3'd2, 16'd48000, 16'd4000, 1'b0, 32'd0);
        tick();
        chk("gen_top", en_fir_top, 1);
        tick(10); coef_busy = 1'b1;
        tick(30); coef_busy = 1'b0;
        push(3'd3, 16'd48000, 16'd4000, 1'b0, 32'd0);
        tick();
        chk("wait_state", state, 3);
        chk("wait_top", en_fir_top, 1);
        run = 1'b1;
        tick(3);
        push(3'd4, 16'd48000, 16'd4000, 1'b0, 32'd0);
        fir_ready = 1'b1;
        tick();
        chk("run_done_pulse", cfg_done, 1);
        chk("run_deal_first", en_fir_deal, 0);
        tick();
        chk("run_done_clear", cfg_done, 0);
        chk("run_deal_on", en_fir_deal, 1);

        // fir_ready drop inside RUN
        fir_ready = 1'b0;
        tick();
        chk("rdy_drop_deal", en_fir_deal, 0);
        chk("rdy_drop_state", state, 4);
        fir_ready = 1'b1;
        tick();
        chk("rdy_back_deal", en_fir_deal, 1);

        // 100 output samples, then reconfigure through DRAIN
        fir_valid = 1'b1;
        tick(100);
        fir_valid = 1'b0;
        chk("sample_cnt_100", sample_cnt, 100);
        push(3'd5, 16'd48000, 16'd4000, 1'b0, 32'd100);
        cfg_load = 1'b1;
        tick(); cfg_load = 1'b0;
        chk("drain_deal", en_fir_deal, 0);
        chk("drain_top", en_fir_top, 1);
        cfg_fs = 16'd44100;
        tick(31);
        chk("drain_len_31", state, 5);
        push(3'd1, 16'd44100, 16'd4000, 1'b0, 32'd100);
        tick();
        chk("drain_to_latch", state, 1);
        push(3'd2, 16'd44100, 16'd4000, 1'b0, 32'd100);
        tick(2);
        chk("regen_state", state, 2);
        coef_busy = 1'b1;
        tick(); coef_busy = 1'b0;
        push(3'd3, 16'd44100, 16'd4000, 1'b0, 32'd100);
        push(3'd4, 16'd44100, 16'd4000, 1'b0, 32'd0);
        tick();
        chk("rewait_state", state, 3);
        tick();
        chk("rerun_cnt_clear", sample_cnt, 0);
        tick();

        // Input change without cfg_load while running
        cfg_fln = 16'd8000;
`ifdef FIR_SEQ_AUTO_RELOAD_EN
        push(3'd5, 16'd44100, 16'd4000, 1'b0, 32'd0);
        tick(2);
        chk("auto_drain_state", state, 5);
        chk("auto_drain_deal", en_fir_deal, 0);
`else
        tick(3);
        chk("noauto_state", state, 4);
        chk("noauto_deal", en_fir_deal, 1);
        chk("noauto_fln", fln_out, 4000);
`endif
        rst_n = 1'b0;
        #1;
        chk("rst_run_state", state, 0);
        tick(2);
        rst_n = 1'b1;
        tick();

        // GEN timeout with coef_busy never rising
        cfg_fs = 16'd1000; cfg_fln = 16'd100; cfg_load = 1'b1;
        push(3'd1, 16'd1000, 16'd100, 1'b0, 32'd0);
        tick(); cfg_load = 1'b0;
        push(3'd2, 16'd1000, 16'd100, 1'b0, 32'd0);
        tick(2);
        chk("to_gen_state", state, 2);
        push(3'd6, 16'd1000, 16'd100, 1'b1, 32'd0);
        tick(63);
        chk("to_gen_63", state, 2);
        chk("to_err_63", err_timeout, 0);
        tick();
        chk("to_err_state", state, 6);
        chk("to_err_flag", err_timeout, 1);
        chk("to_err_top", en_fir_top, 0);
        chk("to_err_deal", en_fir_deal, 0);
        cfg_load = 1'b1;
        push(3'd1, 16'd1000, 16'd100, 1'b0, 32'd0);
        tick(); cfg_load = 1'b0;
        chk("err_clear", err_timeout, 0);
        chk("err_to_latch", state, 1);

        // Restart in LATCH's second cycle
        tick();
        chk("latch2_state", state, 1);
        cfg_fs = 16'd2000; cfg_load = 1'b1;
        tick(); cfg_load = 1'b0;
        chk("relatch_state", state, 1);
        chk("relatch_fs", fs_out, 2000);
        tick();
        chk("relatch_len", state, 1);
        push(3'd2, 16'd2000, 16'd100, 1'b0, 32'd0);
        tick();
        chk("relatch_gen", state, 2);

        // Restart from GEN
        tick(5);
        cfg_fs = 16'd3000; cfg_load = 1'b1;
        push(3'd1, 16'd3000, 16'd100, 1'b0, 32'd0);
        tick(); cfg_load = 1'b0;
        chk("gen_restart_fs", fs_out, 3000);
        push(3'd2, 16'd3000, 16'd100, 1'b0, 32'd0);
        tick(2);
        chk("gen_restart_state", state, 2);

        // Asynchronous reset in GEN
        tick(3);
        rst_n = 1'b0;
        #1;
        chk_reset_values("rst_gen");
        tick(2);
        rst_n = 1'b1;
        tick(2);
        chk("post_rst_idle", state, 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
